// File: rtl/inv_key_schedule_pkg.sv
// ---------------------------------------------------------------------------
// inv_key_schedule_pkg
//   Shared constants for the AES-128 decryption key scheduler:
//   - NR           : number of AES-128 rounds (fixed at 10)
//   - ST_*         : FSM state encodings (IDLE / FWD / REV)
//   - SBOX         : AES forward S-box table
//   - rcon_word()  : round constant for rounds 1..10, byte placed in [31:24]
// ---------------------------------------------------------------------------
package inv_key_schedule_pkg;

   localparam int NR = 10;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_FWD  = 2'd1;
   localparam logic [1:0] ST_REV  = 2'd2;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Round constant RCON[idx] for idx 1..10; any other index yields zero.
   function automatic logic [31:0] rcon_word(input logic [3:0] idx);
      logic [7:0] b;
      case (idx)
         4'd1:    b = 8'h01;
         4'd2:    b = 8'h02;
         4'd3:    b = 8'h04;
         4'd4:    b = 8'h08;
         4'd5:    b = 8'h10;
         4'd6:    b = 8'h20;
         4'd7:    b = 8'h40;
         4'd8:    b = 8'h80;
         4'd9:    b = 8'h1b;
         4'd10:   b = 8'h36;
         default: b = 8'h00;
      endcase
      return {b, 24'h000000};
   endfunction

endpackage

// File: rtl/inv_key_schedule_key_step.sv
// ---------------------------------------------------------------------------
// inv_key_schedule_key_step
//   One step of the AES-128 key schedule in either direction (combinational).
//   Forward and inverse share a single SubWord instance: the forward step
//   substitutes w3, the inverse step substitutes p3 = w3 ^ w2, which is the
//   previous round's w3.
//   Ports:
//     cur_i  [127:0]  current round key {w0,w1,w2,w3}
//     rcon_i [31:0]   round constant, byte in [31:24]
//     dir_i           0 = forward (round i -> i+1), 1 = inverse (i -> i-1)
//     nxt_o  [127:0]  resulting round key
// ---------------------------------------------------------------------------
module inv_key_schedule_key_step
   import inv_key_schedule_pkg::*;
(
   input  logic [127:0] cur_i,
   input  logic [31:0]  rcon_i,
   input  logic         dir_i,
   output logic [127:0] nxt_o
);

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] p3;
   logic [31:0] sub_in, sub_out, t;
   logic [31:0] f0, f1, f2, f3;
   logic [31:0] i0, i1, i2;

   assign {w0, w1, w2, w3} = cur_i;
   assign p3 = w3 ^ w2;

   // RotWord applied to whichever word feeds the shared S-boxes.
   assign sub_in = dir_i ? {p3[23:0], p3[31:24]} : {w3[23:0], w3[31:24]};

   inv_key_schedule_subword u_subword (
      .word_i (sub_in),
      .word_o (sub_out)
   );

   assign t = sub_out ^ rcon_i;

   // Forward: each new word chains on the previously computed new word.
   assign f0 = w0 ^ t;
   assign f1 = w1 ^ f0;
   assign f2 = w2 ^ f1;
   assign f3 = w3 ^ f2;

   // Inverse: undo the chain from the top word down.
   assign i2 = w2 ^ w1;
   assign i1 = w1 ^ w0;
   assign i0 = w0 ^ t;

   assign nxt_o = dir_i ? {i0, i1, i2, p3} : {f0, f1, f2, f3};

endmodule

// File: rtl/inv_key_schedule_subword.sv
// ---------------------------------------------------------------------------
// inv_key_schedule_subword
//   AES SubWord: applies the S-box to each byte of a 32-bit word.
//   Ports:
//     word_i [31:0]  input word
//     word_o [31:0]  byte-wise S-box substitution of word_i
// ---------------------------------------------------------------------------
module inv_key_schedule_subword
   import inv_key_schedule_pkg::*;
(
   input  logic [31:0] word_i,
   output logic [31:0] word_o
);

   for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
      assign word_o[gi*8 +: 8] = SBOX[word_i[gi*8 +: 8]];
   end

endmodule

// File: rtl/inv_key_schedule.sv
// ---------------------------------------------------------------------------
// inv_key_schedule
//   Sequential AES-128 decryption key scheduler. Accepts a cipher key, walks
//   the forward schedule up to round key 10 (one step per cycle), then hands
//   out round keys 10 down to 0 over a valid/ready interface, regenerating
//   each earlier key with the inverse step.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     key_valid/key_ready cipher key handshake (ready only in IDLE)
//     key      [127:0]    cipher key {w0,w1,w2,w3}
//     flush               synchronous abort back to IDLE
//     rk_valid/rk_ready   round key handshake
//     rk       [127:0]    round key
//     rk_round [3:0]      round index of rk (10..0)
//     rk_last             rk_valid with rk_round == 0
//     busy                high while deriving or streaming keys
// ---------------------------------------------------------------------------
module inv_key_schedule
   import inv_key_schedule_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         key_valid,
   output logic         key_ready,
   input  logic [127:0] key,
   input  logic         flush,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk,
   output logic [3:0]   rk_round,
   output logic         rk_last,
   output logic         busy
);

   localparam logic [3:0] LAST_ROUND = 4'(NR);

   logic [1:0]   state_q, state_d;
   logic [127:0] rk_q, rk_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [3:0]   rk_round_q, rk_round_d;

   logic         step_dir;
   logic [31:0]  step_rcon;
   logic [127:0] step_nxt;

   // Forward walk indexes RCON by the step counter; the reverse walk by the
   // round being left, since inv_step(rk_i) needs the constant of round i.
   assign step_dir  = (state_q == ST_REV);
   assign step_rcon = step_dir ? rcon_word(rk_round_q) : rcon_word(cnt_q);

   inv_key_schedule_key_step u_key_step (
      .cur_i  (rk_q),
      .rcon_i (step_rcon),
      .dir_i  (step_dir),
      .nxt_o  (step_nxt)
   );

   always_comb begin
      state_d    = state_q;
      rk_d       = rk_q;
      cnt_d      = cnt_q;
      rk_round_d = rk_round_q;

      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (key_valid) begin
                  rk_d    = key;
                  cnt_d   = 4'd1;
                  state_d = ST_FWD;
               end
            end
            ST_FWD: begin
               rk_d = step_nxt;
               if (cnt_q == LAST_ROUND) begin
                  // rk now becomes round key 10; counter stays capped.
                  state_d    = ST_REV;
                  rk_round_d = LAST_ROUND;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            ST_REV: begin
               if (rk_ready) begin
                  if (rk_round_q == 4'd0) begin
                     state_d = ST_IDLE;
                  end else begin
                     rk_d       = step_nxt;
                     rk_round_d = rk_round_q - 4'd1;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         rk_q       <= '0;
         cnt_q      <= 4'd0;
         rk_round_q <= 4'd0;
      end else begin
         state_q    <= state_d;
         rk_q       <= rk_d;
         cnt_q      <= cnt_d;
         rk_round_q <= rk_round_d;
      end
   end

   assign key_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign rk_valid  = (state_q == ST_REV);
   assign rk_last   = rk_valid && (rk_round_q == 4'd0);
   assign rk        = rk_q;
   assign rk_round  = rk_round_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
module tb_inv_key_schedule;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         key_valid;
   logic         key_ready;
   logic [127:0] key;
   logic         flush;
   logic         rk_valid;
   logic         rk_ready;
   logic [127:0] rk;
   logic [3:0]   rk_round;
   logic         rk_last;
   logic         busy;

   always #5 clk = ~clk;

   inv_key_schedule dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .key       (key),
      .flush     (flush),
      .rk_valid  (rk_valid),
      .rk_ready  (rk_ready),
      .rk        (rk),
      .rk_round  (rk_round),
      .rk_last   (rk_last),
      .busy      (busy)
   );

   int n_total = 0;
   int n_pass  = 0;

   logic [7:0]   sbox_m [256];
   logic [127:0] exp_rk [11];
   logic [127:0] cap    [11];

   typedef struct {
      logic [127:0] key;
      int           round;
      logic [127:0] rk_exp;
   } vec_t;

   // ---------------- reference model (FIPS-197 arithmetic) ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      logic [7:0] y;
      p = 8'h00;
      x = a;
      y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = {1'b0, y[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      logic [7:0] r;
      r = v;
      for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
      return r;
   endfunction

   // S-box from multiplicative inverse in GF(2^8) followed by the affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int b = 1; b < 256; b++)
            if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                     ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic expand(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] temp;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         temp = w[i-1];
         if (i % 4 == 0) begin
            temp = {temp[23:0], temp[31:24]};
            temp = {sbox_m[temp[31:24]], sbox_m[temp[23:16]],
                    sbox_m[temp[15:8]],  sbox_m[temp[7:0]]} ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ temp;
      end
      for (int r = 0; r < 11; r++)
         exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h required %h", nm, act, req);
   endtask

   // Offer key k, wait for round key 10, then consume 11 keys.
   // rand_ready: random backpressure. poke: keep key_valid high (with a
   // different key) for the whole busy period, which must be ignored.
   task automatic run_seq(input logic [127:0] k, input bit rand_ready, input bit poke);
      int  lat;
      int  stalls;
      bit  done;
      expand(k);
      chk("key_ready_idle", 128'(key_ready), 128'(1'b1));
      key_valid = 1'b1;
      key       = k;
      @(negedge clk);
      key_valid = poke;
      key       = ~k;
      lat = 0;
      while (rk_valid !== 1'b1 && lat < 40) begin
         chk("busy_fwd", 128'(busy), 128'(1'b1));
         if (poke) chk("key_ready_busy", 128'(key_ready), 128'(1'b0));
         @(negedge clk);
         lat++;
      end
      chk("latency", 128'(lat), 128'(10));
      for (int r = 10; r >= 0; r--) begin
         stalls = 0;
         done   = 1'b0;
         while (!done) begin
            rk_ready = rand_ready ? (($urandom_range(0, 1) == 1) || stalls >= 6) : 1'b1;
            chk($sformatf("rk_valid_r%0d", r), 128'(rk_valid), 128'(1'b1));
            chk($sformatf("rk_r%0d", r), rk, exp_rk[r]);
            chk($sformatf("rk_round_r%0d", r), 128'(rk_round), 128'(r));
            chk($sformatf("rk_last_r%0d", r), 128'(rk_last), 128'(r == 0));
            $display("round %0d rk=%h ready=%0d", r, rk, rk_ready);
            cap[r] = rk;
            if (rk_ready) done = 1'b1;
            else stalls++;
            @(negedge clk);
         end
      end
      key_valid = 1'b0;
      rk_ready  = 1'b0;
      chk("rk_valid_after", 128'(rk_valid), 128'(1'b0));
      chk("key_ready_after", 128'(key_ready), 128'(1'b1));
      chk("busy_after", 128'(busy), 128'(1'b0));
   endtask

   task automatic accept(input logic [127:0] k);
      key_valid = 1'b1;
      key       = k;
      @(negedge clk);
      key_valid = 1'b0;
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (rk_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("wait_valid", 128'(rk_valid), 128'(1'b1));
   endtask

   task automatic chk_idle(input string nm);
      chk({nm, "_rk_valid"}, 128'(rk_valid), 128'(1'b0));
      chk({nm, "_key_ready"}, 128'(key_ready), 128'(1'b1));
      chk({nm, "_busy"}, 128'(busy), 128'(1'b0));
   endtask

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   initial begin
      vec_t         vecs [6];
      logic [127:0] last_key;
      bit           have_key;

      vecs[0] = '{FIPS_KEY, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      vecs[1] = '{FIPS_KEY,  9, 128'hac7766f319fadc2128d12941575c006e};
      vecs[2] = '{FIPS_KEY,  1, 128'ha0fafe1788542cb123a339392a6c7605};
      vecs[3] = '{FIPS_KEY,  0, FIPS_KEY};
      vecs[4] = '{128'h0, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
      vecs[5] = '{128'h0,  0, 128'h0};

      rst_n     = 1'b0;
      key_valid = 1'b0;
      key       = '0;
      flush     = 1'b0;
      rk_ready  = 1'b0;
      build_sbox();
      @(negedge clk);
      @(negedge clk);
      chk("reset_rk", rk, 128'h0);
      chk("reset_rk_round", 128'(rk_round), 128'(0));
      chk("reset_rk_last", 128'(rk_last), 128'(1'b0));
      chk_idle("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Known-answer vectors; the zero-key run follows the FIPS run in the
      // cycle right after its round-0 handshake (back-to-back keys).
      have_key = 1'b0;
      last_key = '0;
      for (int i = 0; i < 6; i++) begin
         if (!have_key || vecs[i].key != last_key) begin
            run_seq(vecs[i].key, 1'b0, 1'b0);
            last_key = vecs[i].key;
            have_key = 1'b1;
         end
         chk($sformatf("vec%0d_r%0d", i, vecs[i].round), cap[vecs[i].round], vecs[i].rk_exp);
         $display("vector %0d key=%h round=%0d rk=%h", i, vecs[i].key, vecs[i].round, cap[vecs[i].round]);
      end

      // Random backpressure plus key_valid held high during busy.
      run_seq(FIPS_KEY, 1'b1, 1'b1);

      // Flush during the forward walk.
      accept(128'h00112233445566778899aabbccddeeff);
      repeat (4) @(negedge clk);
      chk("fwd_busy_before_flush", 128'(busy), 128'(1'b1));
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk_idle("flush_fwd");

      // Flush while streaming round 6.
      accept(FIPS_KEY);
      wait_valid();
      rk_ready = 1'b1;
      repeat (4) @(negedge clk);
      chk("round_before_flush", 128'(rk_round), 128'(6));
      rk_ready = 1'b0;
      flush    = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk_idle("flush_rev");
      run_seq({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);

      // Flush in IDLE wins over a coincident key.
      flush     = 1'b1;
      key_valid = 1'b1;
      key       = FIPS_KEY;
      @(negedge clk);
      flush     = 1'b0;
      key_valid = 1'b0;
      chk_idle("flush_idle");
      @(negedge clk);
      chk_idle("flush_idle2");

      // Asynchronous reset in the middle of streaming.
      accept(FIPS_KEY);
      wait_valid();
      rk_ready = 1'b1;
      repeat (2) @(negedge clk);
      rk_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("areset_rk", rk, 128'h0);
      chk("areset_rk_round", 128'(rk_round), 128'(0));
      chk("areset_rk_last", 128'(rk_last), 128'(1'b0));
      chk_idle("areset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_idle("after_areset");
      run_seq(FIPS_KEY, 1'b0, 1'b0);

      // Random keys under random backpressure.
      for (int i = 0; i < 4; i++)
         run_seq({$urandom, $urandom, $urandom, $urandom}, 1'b1, (i % 2) == 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running required finished");
      $fatal(1);
   end

endmodule
